mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//   Bus initiator for the single-port mem request/response interface. Accepts a copy
//   command (src, dst, len) and moves len words from src to dst: it issues reads,
//   buffers the returned data and issues writes. It sits between a control/testbench
//   sequencer and a mem instance, and owns all mem_* request signals.
// PARAMETERS
//   MEM_AW      12  word address width; must match the memory.
//   MEM_DW      32  data width.
//   FIFO_DEPTH  4   read-data buffer entries; power of 2, >= RD_LAT.
//   RD_LAT      2   cycles from a sampled read request to mem_rdata_vld; fixed by the memory.
// PORTS
//   clk            in   1          clock; all logic on posedge.
//   rst_n          in   1          synchronous reset, active-low.
//   cmd_valid      in   1          command offered.
//   cmd_ready      out  1          engine idle, command accepted when valid&ready.
//   cmd_src        in   MEM_AW     source base word address.
//   cmd_dst        in   MEM_AW     destination base word address.
//   cmd_len        in   MEM_AW+1   word count, 0..2^MEM_AW.
//   done           out  1          one-cycle pulse when the last write is issued (or len==0).
//   busy           out  1          command in progress.
//   mem_req        out  1          request strobe, one access per cycle.
//   mem_write      out  1          1=write, 0=read; valid with mem_req.
//   mem_addr       out  MEM_AW     access address.
//   mem_wdata      out  MEM_DW     write data; valid with mem_req&mem_write.
//   mem_rdata      in   MEM_DW     read data.
//   mem_rdata_vld  in   1          read data valid, RD_LAT cycles after the read request.
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): cmd_ready=1, done=0, busy=0, mem_req=0, mem_write=0,
//     mem_addr=0, mem_wdata=0. Counters, FSM and FIFO cleared. A reset mid-copy aborts
//     the command; read data still in flight after reset is discarded (inflight==0).
//   FSM: IDLE -> (cmd_valid, len!=0) RUN; IDLE -> (cmd_valid, len==0) DONE; RUN -> DONE
//     on the cycle the final write is issued; DONE -> IDLE. done=1 only in DONE.
//     cmd_ready=1 only in IDLE. Command fields are registered on accept.
//   All request outputs are registered. Arbitration each RUN cycle:
//     read  if rd_left>0 and fifo_count+inflight < FIFO_DEPTH;
//     else write if fifo not empty (pop); else mem_req=0.
//     Reads take priority, so there is never overflow; writes drain buffered data.
//   inflight counts issued, unreturned reads. It increments on a read issue, decrements
//     on mem_rdata_vld, and both events in one cycle leave it unchanged. mem_rdata_vld
//     with inflight==0 is ignored. Each vld pushes mem_rdata; a push and a pop in the
//     same cycle are both allowed, and the count is unchanged.
//   Addresses increment by 1 per access and wrap modulo 2^MEM_AW (0xFFF -> 0x000).
//   len=2^MEM_AW copies the whole memory. rd_left/wr_left are MEM_AW+1 bits wide.
//   Copy proceeds in ascending order. Results are undefined if dst lies in
//     (src, src+len-1]; dst==src is legal.
//   cmd_valid while busy is not accepted and has no effect.
//   Total cycles from accept to done is at most 2*len + RD_LAT + 2.
// STRUCTURE
//   Shared package mem_if_pkg: MEM_AW/MEM_DW/RD_LAT defaults and the FSM state enum
//     {IDLE, RUN, DONE}, reused by other mem initiators.
//   One sub-module, mem_copy_fifo: synchronous FIFO with FIFO_DEPTH x MEM_DW entries,
//     push/pop/count/empty/full, same clk/rst_n. Top level holds the FSM, counters
//     and arbiter.
// TESTING
//   Reset idle: hold rst_n=0 for 3 cycles -> cmd_ready=1, mem_req=0, busy=0, done=0.
//   init_incr, copy src=0x010 dst=0x100 len=8 -> MEM[0x100..0x107]=0x10..0x17; done pulses
//     once; read/write counts are 8 each; no more than 4 reads outstanding.
//   Wrap: copy src=0xFFE dst=0x7FE len=4 -> reads 0xFFE,0xFFF,0x000,0x001; writes
//     0x7FE..0x801 carry the matching data.
//   len=0 -> done one cycle after accept, no mem_req, cmd_ready=1 on the next cycle.
//   Reset mid-copy: len=16, assert rst_n=0 after 6 requests -> outputs at reset values
//     next edge; late mem_rdata_vld ignored; new copy len=2 completes correctly.
//   Command while busy: pulse cmd_valid during RUN -> ignored; the first copy completes
//     unchanged and a single done pulse occurs.

Source files
------------

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared defaults and FSM state type for mem bus initiators
//
// Purpose: common word-address/data widths, memory read latency and the
//   IDLE/RUN/DONE command state enum used by mem request/response initiators.
// Ports: none (package).

package mem_if_pkg;

  localparam int MEM_AW_DEF = 12;
  localparam int MEM_DW_DEF = 32;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } copy_state_e;

endpackage

// File: rtl/mem_copy_fifo.sv
// rtl/mem_copy_fifo.sv - synchronous read-data buffer for the copy engine
//
// Purpose: DEPTH x DW synchronous FIFO with first-word-fall-through read port.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (clears pointers/count)
//   push, push_data  write an entry (ignored when full unless popping too)
//   pop, pop_data    remove the head entry; pop_data shows the head combinationally
//   count          number of stored entries, 0..DEPTH
//   empty, full    status flags derived from count

module mem_copy_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DW-1:0] store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is still fine when the same cycle frees a slot.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - mem bus initiator copying len words from src to dst
//
// Purpose: accepts a (src, dst, len) command, issues ascending reads, buffers the
//   returned words and writes them out ascending from dst. Reads win arbitration
//   while buffer space (including in-flight reads) remains; otherwise a buffered
//   word is written.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_src, cmd_dst, cmd_len     source/destination word address, word count
//   done                          one-cycle pulse with the last write (or len==0)
//   busy                          command in progress
//   mem_req/mem_write/mem_addr/mem_wdata   registered request outputs
//   mem_rdata/mem_rdata_vld       read return, RD_LAT cycles after a sampled read

module mem_copy_engine
  import mem_if_pkg::*;
#(
  parameter int MEM_AW     = MEM_AW_DEF,
  parameter int MEM_DW     = MEM_DW_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MEM_AW-1:0] cmd_src,
  input  logic [MEM_AW-1:0] cmd_dst,
  input  logic [MEM_AW:0]   cmd_len,
  output logic              done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic [MEM_DW-1:0] mem_rdata,
  input  logic              mem_rdata_vld
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [MEM_AW-1:0] ADDR_ONE  = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [MEM_AW:0]   LEN_ONE   = {{MEM_AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]       DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

  // The buffer must absorb every read that can be in flight.
  if (FIFO_DEPTH < RD_LAT || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("mem_copy_engine: FIFO_DEPTH must be a power of 2 and >= RD_LAT");
  end

  copy_state_e       state;
  copy_state_e       next_state;
  logic [MEM_AW-1:0] rd_addr;
  logic [MEM_AW-1:0] wr_addr;
  logic [MEM_AW:0]   rd_left;
  logic [MEM_AW:0]   wr_left;
  logic [CW-1:0]     inflight;

  logic [MEM_DW-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW:0]       occupancy;
  logic              issue_rd;
  logic              issue_wr;
  logic              ret_vld;

  mem_copy_fifo #(
    .DW    (MEM_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ret_vld),
    .push_data (mem_rdata),
    .pop       (issue_wr),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Reserve a slot for each outstanding read so returns can never overflow.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_rd  = (state == RUN) && (rd_left != '0) && (occupancy < DEPTH_LIM) && !fifo_full;
  assign issue_wr  = (state == RUN) && !issue_rd && !fifo_empty;
  // Returns with nothing outstanding belong to a command killed by reset.
  assign ret_vld   = mem_rdata_vld && (inflight != '0);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_valid) next_state = (cmd_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (issue_wr && (wr_left == LEN_ONE)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      wr_addr   <= '0;
      rd_left   <= '0;
      wr_left   <= '0;
      inflight  <= '0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= next_state;
      mem_req   <= issue_rd || issue_wr;
      mem_write <= issue_wr;

      if (state == IDLE && cmd_valid) begin
        rd_addr <= cmd_src;
        wr_addr <= cmd_dst;
        rd_left <= cmd_len;
        wr_left <= cmd_len;
      end else if (issue_rd) begin
        mem_addr <= rd_addr;
        rd_addr  <= rd_addr + ADDR_ONE;
        rd_left  <= rd_left - LEN_ONE;
      end else if (issue_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= fifo_rdata;
        wr_addr   <= wr_addr + ADDR_ONE;
        wr_left   <= wr_left - LEN_ONE;
      end

      case ({issue_rd, ret_vld})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - table-driven bench for mem_copy_engine

module tb_mem_copy_engine;

  typedef struct {
    logic [11:0] src;
    logic [11:0] dst;
    logic [12:0] len;
    int          poke_at;
    int          exp_reads;
    int          exp_writes;
    int          exp_done;
    int          max_cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_src;
  logic [11:0] cmd_dst;
  logic [12:0] cmd_len;
  logic        done;
  logic        busy;
  logic        mem_req;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdata_vld;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(
    .MEM_AW     (12),
    .MEM_DW     (32),
    .FIFO_DEPTH (4),
    .RD_LAT     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_src       (cmd_src),
    .cmd_dst       (cmd_dst),
    .cmd_len       (cmd_len),
    .done          (done),
    .busy          (busy),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_rdata_vld (mem_rdata_vld)
  );

  // Memory model: word a initially holds a; reads return two cycles after sampling.
  logic [31:0] tb_mem [0:4095];
  logic        mem_ready = 1'b0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_d = '0, s2_d = '0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 4096; a++) tb_mem[a] <= 32'(a);
      mem_ready <= 1'b1;
    end else if (mem_req && mem_write) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
    s1_v <= mem_req && !mem_write;
    s1_d <= tb_mem[mem_addr];
    s2_v <= s1_v;
    s2_d <= s1_d;
  end
  assign mem_rdata_vld = s2_v;
  assign mem_rdata     = s2_d;

  // Request log.
  logic        log_clr = 1'b0;
  logic [11:0] rd_q[$];
  logic [11:0] wr_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  int          out_cnt = 0;
  int          max_out = 0;

  always @(posedge clk) begin
    int o;
    if (log_clr) begin
      rd_q.delete();
      wr_q.delete();
      wd_q.delete();
      done_cnt <= 0;
      out_cnt  <= 0;
      max_out  <= 0;
    end else begin
      if (mem_req && !mem_write) rd_q.push_back(mem_addr);
      if (mem_req && mem_write) begin
        wr_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
      end
      if (done) done_cnt <= done_cnt + 1;
      o = out_cnt + ((mem_req && !mem_write) ? 1 : 0) - (mem_rdata_vld ? 1 : 0);
      if (o < 0) o = 0;
      out_cnt <= o;
      if (o > max_out) max_out <= o;
    end
  end

  logic [31:0] golden [0:4095];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s actual=%0d expected<=%0d", name, act, lim);
    end
  endtask

  task automatic pulse_log_clr();
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  task automatic do_copy(input vec_t v, input string name);
    logic [31:0] exp_wd[$];
    logic [11:0] a;
    int          cycles;
    bit          ok;
    bit          done_seen;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.src + 12'(i);
      exp_wd.push_back(golden[a]);
    end
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.dst + 12'(i);
      golden[a] = exp_wd[i];
    end
    pulse_log_clr();
    check({name, "_ready_pre"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_src   = v.src;
    cmd_dst   = v.dst;
    cmd_len   = v.len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cycles = 0;
    while (!done && cycles < 500) begin
      if (cycles == v.poke_at) begin
        cmd_valid = 1'b1;
        cmd_src   = 12'h000;
        cmd_dst   = 12'h010;
        cmd_len   = 13'd3;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cycles++;
    end
    done_seen = done;
    check({name, "_done_seen"}, 64'(done_seen), 64'(1));
    check_le({name, "_cycles"}, cycles, v.max_cycles);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_cnt), 64'(v.exp_done));
    check({name, "_reads"}, 64'(rd_q.size()), 64'(v.exp_reads));
    check({name, "_writes"}, 64'(wr_q.size()), 64'(v.exp_writes));
    ok = (rd_q.size() == v.exp_reads);
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== v.src + 12'(i)) ok = 1'b0;
    check({name, "_rd_order"}, 64'(ok), 64'(1));
    ok = (wr_q.size() == v.exp_writes);
    for (int i = 0; i < wr_q.size() && i < exp_wd.size(); i++)
      if (wr_q[i] !== v.dst + 12'(i) || wd_q[i] !== exp_wd[i]) ok = 1'b0;
    check({name, "_wr_addr_data"}, 64'(ok), 64'(1));
    ok = 1'b1;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.dst + 12'(i);
      if (tb_mem[a] !== golden[a]) ok = 1'b0;
    end
    check({name, "_mem_contents"}, 64'(ok), 64'(1));
    check_le({name, "_max_outstanding"}, max_out, 4);
    check({name, "_idle_after"}, 64'({cmd_ready, busy, done}), 64'(3'b100));
  endtask

  vec_t vecs[6];

  initial begin
    vec_t v;
    int   guard;
    int   stray;

    for (int a = 0; a < 4096; a++) golden[a] = 32'(a);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_len = '0;

    //            src      dst      len     poke rd  wr  done maxcyc
    vecs[0] = '{12'h010, 12'h100, 13'd8,  -1, 8,  8,  1, 20};
    vecs[1] = '{12'hFFE, 12'h7FE, 13'd4,  -1, 4,  4,  1, 12};
    vecs[2] = '{12'h020, 12'h500, 13'd0,  -1, 0,  0,  1, 0};
    vecs[3] = '{12'h200, 12'h300, 13'd1,  -1, 1,  1,  1, 6};
    vecs[4] = '{12'h400, 12'h400, 13'd5,  -1, 5,  5,  1, 14};
    vecs[5] = '{12'h060, 12'h700, 13'd8,   3, 8,  8,  1, 20};

    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", 64'({cmd_ready, busy, done, mem_req, mem_write, mem_addr, mem_wdata}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_copy(vecs[i], $sformatf("vec%0d", i));

    // len==0: cmd_ready returns the cycle after the done pulse.
    pulse_log_clr();
    cmd_valid = 1'b1; cmd_src = 12'h030; cmd_dst = 12'h530; cmd_len = 13'd0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("len0_done_now", 64'({done, cmd_ready}), 64'(2'b10));
    @(posedge clk);
    #1;
    check("len0_ready_next", 64'({done, cmd_ready, mem_req}), 64'(3'b010));

    // Reset in the middle of a 16-word copy.
    pulse_log_clr();
    cmd_valid = 1'b1; cmd_src = 12'h040; cmd_dst = 12'h140; cmd_len = 13'd16;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    guard = 0;
    while ((rd_q.size() + wr_q.size()) < 6 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_6_requests", 64'(guard < 100), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_reset_outputs", 64'({cmd_ready, busy, done, mem_req, mem_write, mem_addr, mem_wdata}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (mem_req || busy) stray++;
    end
    check("abort_quiet_after_reset", 64'(stray), 64'(0));
    // The aborted copy partially wrote 0x140.., so resync the model there.
    for (int i = 0; i < 16; i++) golden[12'h140 + i] = tb_mem[12'h140 + i];
    v = '{12'h050, 12'h250, 13'd2, -1, 2, 2, 1, 8};
    do_copy(v, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
